// File: rtl/freq_check_ctrl.sv
// freq_check_ctrl -- sequencer for an external frequency comparator.
//
// The block launches measurements on the comparator, collects the results,
// and tracks runs of consecutive failures. It runs either one single-shot
// measurement or a continuous series of measurements. In continuous mode an
// optional idle gap of `interval` cycles separates one measurement from the
// next.
//
// Optional feature: define FREQ_CHECK_WDOG_EN to build in a WAIT-state
// watchdog. A watchdog expiry sets wdog_err and counts as a failed
// measurement. When the macro is undefined, wdog_err is tied to 0 and WAIT
// waits for cmp_done with no time limit.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   start / stop        one-cycle requests to begin / end measuring
//   continuous          repeat mode, latched when start is accepted
//   timeout_value       comparator window, latched when start is accepted
//   interval            gap between continuous measurements, latched at start
//   fail_limit          consecutive fails that raise alarm (0 = disabled)
//   wd_limit            watchdog limit in WAIT cycles (watchdog builds only)
//   clear               clears alarm, wdog_err and fail_count
//   cmp_enable          launch pulse to the comparator
//   cmp_timeout_value   window value driven to the comparator
//   cmp_done, cmp_ge    comparator completion pulse and result
//   busy                state is not IDLE
//   result_valid        one-cycle result strobe; result_ge holds last result
//   fail_count          consecutive-fail counter (saturating)
//   alarm, wdog_err     sticky status flags
module freq_check_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [DATA_WIDTH-1:0] timeout_value,
    input  logic [CNT_WIDTH-1:0]  interval,
    input  logic [CNT_WIDTH-1:0]  fail_limit,
    input  logic [DATA_WIDTH-1:0] wd_limit,
    input  logic                  clear,
    output logic                  cmp_enable,
    output logic [DATA_WIDTH-1:0] cmp_timeout_value,
    input  logic                  cmp_done,
    input  logic                  cmp_ge,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  result_ge,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  alarm,
    output logic                  wdog_err
);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state, state_nx;
    logic                 cont_r;
    logic [CNT_WIDTH-1:0] interval_r;
    logic [CNT_WIDTH-1:0] gap_cnt;
    logic                 stop_pend;
    logic                 done_ev;
    logic                 wd_hit;
    logic                 meas_end;
    logic                 fail_ev;
    logic                 pass_ev;
    logic                 stop_eff;
    logic [CNT_WIDTH-1:0] fc_inc;

    // A cmp_done pulse counts only in WAIT. Anywhere else it is a stray pulse.
    assign done_ev  = (state == WAIT) && cmp_done;
    assign meas_end = done_ev || wd_hit;
    assign pass_ev  = done_ev && cmp_ge;
    assign fail_ev  = (done_ev && !cmp_ge) || wd_hit;
    // A stop in the current cycle counts like one already pending. The exit
    // decision then sees it without an extra cycle of latency.
    assign stop_eff = stop_pend || stop;
    assign fc_inc   = (fail_count == {CNT_WIDTH{1'b1}}) ? fail_count : fail_count + CNT_ONE;
    assign busy     = (state != IDLE);

`ifdef FREQ_CHECK_WDOG_EN
    localparam logic [DATA_WIDTH-1:0] WD_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    logic [DATA_WIDTH-1:0] wd_cnt;

    // wd_cnt holds (WAIT cycles so far - 1). The limit is therefore hit on
    // the wd_limit-th WAIT cycle. A simultaneous cmp_done takes precedence.
    assign wd_hit = (state == WAIT) && !cmp_done && ((wd_cnt + WD_ONE) == wd_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt   <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (state == START)
                wd_cnt <= '0;
            else if (state == WAIT)
                wd_cnt <= wd_cnt + WD_ONE;
            if (clear)
                wdog_err <= 1'b0;
            else if (wd_hit)
                wdog_err <= 1'b1;
        end
    end
`else
    logic unused_wd_limit;
    assign unused_wd_limit = ^wd_limit;
    assign wd_hit          = 1'b0;
    assign wdog_err        = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = START;
            START: state_nx = WAIT;
            WAIT: begin
                if (meas_end) begin
                    if (!cont_r || stop_eff)
                        state_nx = IDLE;
                    else if (interval_r == '0)
                        state_nx = START;
                    else
                        state_nx = GAP;
                end
            end
            GAP: begin
                if (stop_eff)
                    state_nx = IDLE;
                else if (gap_cnt == CNT_ONE)
                    state_nx = START;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            stop_pend         <= 1'b0;
            cont_r            <= 1'b0;
            interval_r        <= '0;
            gap_cnt           <= '0;
            cmp_enable        <= 1'b0;
            cmp_timeout_value <= '0;
            result_valid      <= 1'b0;
            result_ge         <= 1'b0;
            fail_count        <= '0;
            alarm             <= 1'b0;
        end else begin
            state        <= state_nx;
            // The launch pulse is registered from the next state, so it is
            // high exactly during the START cycle.
            cmp_enable   <= (state_nx == START);
            result_valid <= done_ev;
            if (done_ev)
                result_ge <= cmp_ge;

            // The run parameters change only in IDLE. cmp_timeout_value
            // therefore stays stable for the whole measurement.
            if (state == IDLE && start) begin
                cont_r            <= continuous;
                interval_r        <= interval;
                cmp_timeout_value <= timeout_value;
            end

            if (state_nx == IDLE)
                stop_pend <= 1'b0;
            else if (state != IDLE && stop)
                stop_pend <= 1'b1;

            // gap_cnt is loaded with the gap length on entry to GAP. GAP
            // leaves on the cycle where gap_cnt reads 1.
            if (state == WAIT && state_nx == GAP)
                gap_cnt <= interval_r;
            else if (state == GAP)
                gap_cnt <= gap_cnt - CNT_ONE;

            // clear takes precedence over a simultaneous fail, including a
            // fail that would reach fail_limit.
            if (clear) begin
                fail_count <= '0;
                alarm      <= 1'b0;
            end else if (pass_ev) begin
                fail_count <= '0;
            end else if (fail_ev) begin
                fail_count <= fc_inc;
                if (fail_limit != '0 && fc_inc == fail_limit)
                    alarm <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_check_ctrl.sv
// Directed bench for freq_check_ctrl. Each expected comparator result is
// queued when cmp_done is driven. The queue entry is popped when result_valid
// strobes.
module tb_freq_check_ctrl;
    localparam int DW = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset, start, stop, continuous, clear, cmp_done, cmp_ge;
    logic [DW-1:0] timeout_value, wd_limit;
    logic [CW-1:0] interval, fail_limit;
    logic          cmp_enable, busy, result_valid, result_ge, alarm, wdog_err;
    logic [DW-1:0] cmp_timeout_value;
    logic [CW-1:0] fail_count;

    int   checks = 0;
    int   errors = 0;
    logic sb[$];

    freq_check_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .continuous(continuous), .timeout_value(timeout_value),
        .interval(interval), .fail_limit(fail_limit), .wd_limit(wd_limit),
        .clear(clear), .cmp_enable(cmp_enable),
        .cmp_timeout_value(cmp_timeout_value), .cmp_done(cmp_done),
        .cmp_ge(cmp_ge), .busy(busy), .result_valid(result_valid),
        .result_ge(result_ge), .fail_count(fail_count), .alarm(alarm),
        .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample #1 after the edge. The result scoreboard
    // runs here, so every strobe is seen.
    task automatic tick();
        logic e;
        @(posedge clk);
        #1;
        if (result_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL unexpected_result_valid: observed 1 expected 0");
            end else begin
                e = sb.pop_front();
                assert (result_ge === e) else begin
                    errors++;
                    $error("FAIL result_ge: observed %0b expected %0b", result_ge, e);
                end
            end
        end
    endtask

    // Pulse cmp_done for one cycle. On return the bench sits on the
    // result_valid cycle.
    task automatic done(input logic ge);
        cmp_done = 1'b1;
        cmp_ge   = ge;
        sb.push_back(ge);
        tick();
        cmp_done = 1'b0;
        cmp_ge   = 1'b0;
    endtask

    task automatic begin_run(input logic cont, input logic [CW-1:0] ivl, input logic [DW-1:0] tv);
        continuous    = cont;
        interval      = ivl;
        timeout_value = tv;
        start         = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int  n;
        logic seen;
        reset = 1'b1; start = 0; stop = 0; continuous = 0; clear = 0;
        cmp_done = 0; cmp_ge = 0; timeout_value = '0; wd_limit = 16'd10;
        interval = '0; fail_limit = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_cmp_enable", cmp_enable, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_fail_count", fail_count, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_wdog_err", wdog_err, 0);
        chk("rst_cmp_tv", cmp_timeout_value, 0);
        reset = 1'b0;
        tick();

        // Single-shot measurement with cmp_done 3 cycles after cmp_enable.
        begin_run(1'b0, 3'd0, 16'd100);
        chk("ss_enable", cmp_enable, 1);
        chk("ss_busy", busy, 1);
        chk("ss_tv", cmp_timeout_value, 100);
        timeout_value = 16'd55;
        tick();
        chk("ss_enable_low", cmp_enable, 0);
        tick(); tick();
        chk("ss_tv_hold", cmp_timeout_value, 100);
        done(1'b1);
        chk("ss_rv", result_valid, 1);
        chk("ss_idle", busy, 0);
        tick();
        chk("ss_rv_low", result_valid, 0);
        chk("ss_ge_hold", result_ge, 1);

        // Continuous, interval 5: five GAP cycles before the next launch.
        begin_run(1'b1, 3'd5, 16'd7);
        tick();
        done(1'b1);
        chk("gap_busy", busy, 1);
        n = 0;
        while (cmp_enable !== 1'b1 && n < 20) begin tick(); n++; end
        chk("gap_len", n, 5);
        // A stop during WAIT still lets the pending result through.
        stop = 1'b1; tick(); stop = 1'b0;
        tick(); tick();
        done(1'b0);
        chk("stopw_idle", busy, 0);
        chk("stopw_fc", fail_count, 1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); if (cmp_enable) seen = 1'b1; end
        chk("stopw_no_enable", seen, 0);

        // Clearing resets the fail count. A continuous run with interval 0
        // relaunches right away.
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_fc", fail_count, 0);
        begin_run(1'b1, 3'd0, 16'd9);
        tick();
        done(1'b1);
        chk("ivl0_enable1", cmp_enable, 1);
        tick();
        done(1'b1);
        chk("ivl0_enable2", cmp_enable, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        done(1'b1);
        chk("ivl0_stop_idle", busy, 0);
        chk("ivl0_stop_enable", cmp_enable, 0);

        // A stop in GAP ends the run on the next cycle.
        begin_run(1'b1, 3'd4, 16'd9);
        tick();
        done(1'b1);
        tick();
        chk("gap_stop_pre", busy, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("gap_stop_idle", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); if (cmp_enable) seen = 1'b1; end
        chk("gap_stop_no_enable", seen, 0);

        // Alarm at three consecutive fails. The alarm survives a pass and
        // drops on clear.
        fail_limit = 3'd3;
        begin_run(1'b1, 3'd0, 16'd9);
        tick();
        done(1'b0);
        chk("al_fc1", fail_count, 1);
        chk("al_a1", alarm, 0);
        tick(); done(1'b0);
        chk("al_fc2", fail_count, 2);
        chk("al_a2", alarm, 0);
        tick(); done(1'b0);
        chk("al_fc3", fail_count, 3);
        chk("al_a3", alarm, 1);
        tick(); done(1'b1);
        chk("al_pass_fc", fail_count, 0);
        chk("al_pass_alarm", alarm, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        chk("al_clear", alarm, 0);
        done(1'b0);
        chk("al_post_fc", fail_count, 1);
        chk("al_post_idle", busy, 0);

        // A clear in the same cycle as a fail that would reach the limit:
        // clear takes precedence.
        fail_limit = 3'd2;
        begin_run(1'b1, 3'd0, 16'd9);
        tick();
        clear = 1'b1;
        done(1'b0);
        clear = 1'b0;
        chk("clrwin_fc", fail_count, 0);
        chk("clrwin_alarm", alarm, 0);
        tick();
        stop = 1'b1;
        done(1'b0);
        stop = 1'b0;
        chk("clrwin_fc2", fail_count, 1);
        chk("clrwin_idle", busy, 0);

        // The fail counter saturates at all-ones. With limit 0 the alarm
        // stays off.
        fail_limit = 3'd0;
        begin_run(1'b1, 3'd0, 16'd9);
        tick();
        for (int i = 0; i < 9; i++) begin done(1'b0); tick(); end
        chk("sat_fc", fail_count, 7);
        chk("sat_alarm", alarm, 0);
        stop = 1'b1;
        done(1'b1);
        stop = 1'b0;
        chk("sat_pass_fc", fail_count, 0);
        chk("sat_idle", busy, 0);

        // Watchdog behaviour.
        begin_run(1'b0, 3'd0, 16'd9);
        tick();
`ifdef FREQ_CHECK_WDOG_EN
        repeat (9) tick();
        chk("wd_pre", wdog_err, 0);
        chk("wd_pre_busy", busy, 1);
        tick();
        chk("wd_err", wdog_err, 1);
        chk("wd_fc", fail_count, 1);
        chk("wd_idle", busy, 0);
        chk("wd_no_rv", result_valid, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("wd_clear", wdog_err, 0);
`else
        repeat (30) tick();
        chk("nowd_busy", busy, 1);
        chk("nowd_err", wdog_err, 0);
        done(1'b1);
        chk("nowd_idle", busy, 0);
`endif

        // Reset during WAIT, then a late cmp_done that must be ignored.
        begin_run(1'b1, 3'd2, 16'd33);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        cmp_done = 1'b1; cmp_ge = 1'b1;
        tick();
        cmp_done = 1'b0; cmp_ge = 1'b0;
        tick();
        chk("rmw_busy", busy, 0);
        chk("rmw_rv", result_valid, 0);
        chk("rmw_ge", result_ge, 0);
        chk("rmw_enable", cmp_enable, 0);
        chk("rmw_tv", cmp_timeout_value, 0);
        chk("rmw_fc", fail_count, 0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/freq_check_ctrl.md
FREQ_CHECK_CTRL -- requirements
Module: freq_check_ctrl

Interface
- REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the comparator timeout value and the watchdog limit.
- REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, giving the width of the interval, fail-limit and fail-counter fields.
- REQ-003 clk  in  1  single clock; every register SHALL be clocked on posedge clk.
- REQ-004 reset  in  1  synchronous, active-high reset.
- REQ-005 start  in  1  one-cycle request to begin measuring.
- REQ-006 stop  in  1  one-cycle request to end continuous measuring.
- REQ-007 continuous  in  1  1 = repeat measurements, 0 = single shot; sampled when start is accepted.
- REQ-008 timeout_value  in  DATA_WIDTH  reference-clock window; latched when start is accepted.
- REQ-009 interval  in  CNT_WIDTH  idle gap in cycles between continuous measurements; latched when start is accepted.
- REQ-010 fail_limit  in  CNT_WIDTH  number of consecutive fails that raises alarm; 0 = alarm disabled.
- REQ-011 wd_limit  in  DATA_WIDTH  watchdog limit in cycles spent in WAIT.
- REQ-012 clear  in  1  clears alarm, wdog_err and fail_count.
- REQ-013 cmp_enable  out  1  launch pulse to the comparator.
- REQ-014 cmp_timeout_value  out  DATA_WIDTH  window value driven to the comparator.
- REQ-015 cmp_done  in  1  one-cycle comparator completion pulse.
- REQ-016 cmp_ge  in  1  comparator result; valid only when cmp_done=1.
- REQ-017 busy  out  1  1 whenever state is not IDLE.
- REQ-018 result_valid  out  1  one-cycle result strobe.
- REQ-019 result_ge  out  1  last result; holds its value between strobes.
- REQ-020 fail_count  out  CNT_WIDTH  consecutive-fail counter.
- REQ-021 alarm  out  1  sticky consecutive-fail alarm.
- REQ-022 wdog_err  out  1  sticky watchdog error flag.

Function
- REQ-023 The block SHALL implement the states IDLE, START, WAIT and GAP.
- REQ-024 IDLE SHALL go to START on the cycle after start=1; start SHALL be ignored in every other state.
- REQ-025 cmp_enable SHALL be 1 only during the single START cycle; START SHALL always go to WAIT.
- REQ-026 cmp_timeout_value SHALL be driven from the latched register and held stable from START until WAIT exits.
- REQ-027 When cmp_done=1 in WAIT, the cycle after SHALL have result_valid=1 and result_ge equal to the sampled cmp_ge.
- REQ-028 cmp_done outside WAIT SHALL be ignored.
- REQ-029 A fail (cmp_ge=0) SHALL increment fail_count, saturating at all-ones.
- REQ-030 A pass (cmp_ge=1) SHALL reset fail_count to 0.
- REQ-031 alarm SHALL set on the cycle fail_count first reaches fail_limit (fail_limit != 0) and SHALL stay set until clear or reset, even through later passes.
- REQ-032 On WAIT exit, the next state SHALL be IDLE if in single-shot mode or if a stop is pending.
- REQ-033 Otherwise the next state SHALL be START if interval=0, else GAP.
- REQ-034 GAP SHALL last exactly interval cycles, then go to START.
- REQ-035 stop SHALL set a pending flag in any non-IDLE state and SHALL be ignored in IDLE.
- REQ-036 If stop is pending in GAP, the block SHALL go to IDLE on the next cycle; the pending flag SHALL clear on entry to IDLE.
- REQ-037 An in-flight WAIT SHALL always complete; stop SHALL never abort it.
- REQ-038 If clear and a fail strobe occur in the same cycle, clear SHALL win.
- REQ-039 If a fail strobe and reaching fail_limit coincide with clear, alarm SHALL be 0.

Reset
- REQ-040 reset=1 SHALL force state IDLE and clear the stop-pending flag.
- REQ-041 reset=1 SHALL force cmp_enable, result_valid, result_ge, fail_count, alarm and wdog_err to 0.
- REQ-042 reset=1 SHALL force cmp_timeout_value to 0.
- REQ-043 Reset asserted mid-WAIT SHALL abandon the measurement without a result strobe; a later cmp_done SHALL be ignored.

Configuration
- REQ-044 With macro FREQ_CHECK_WDOG_EN defined, a watchdog counter SHALL count cycles in WAIT and clear on WAIT entry.
- REQ-045 With FREQ_CHECK_WDOG_EN defined, the counter reaching wd_limit without cmp_done SHALL set wdog_err sticky and count as a fail per REQ-029/031.
- REQ-046 With FREQ_CHECK_WDOG_EN defined, a watchdog timeout SHALL produce no result_valid and SHALL exit WAIT per REQ-032/033.
- REQ-047 With FREQ_CHECK_WDOG_EN defined, cmp_done and the watchdog limit in the same cycle SHALL be resolved in favour of cmp_done.
- REQ-048 Without FREQ_CHECK_WDOG_EN, no watchdog counter SHALL exist, wdog_err SHALL be tied to 0, wd_limit SHALL be unused, and WAIT SHALL wait indefinitely.

Verification
- REQ-049 Single shot: continuous=0, timeout_value=100, start; cmp_done with cmp_ge=1 3 cycles after cmp_enable -> one cmp_enable pulse, result_valid one cycle after cmp_done, result_ge=1, return to IDLE, busy=0.
- REQ-050 Continuous gap: interval=5, passes -> exactly 5 GAP cycles between the cycle after result_valid and the next cmp_enable; interval=0 -> cmp_enable the cycle after WAIT exit.
- REQ-051 Alarm: fail_limit=3, fails 1,2,3 -> alarm rises with fail_count=3; a following pass -> fail_count=0, alarm=1; clear -> alarm=0.
- REQ-052 Stop: stop during WAIT -> the result is still strobed, then IDLE with no further cmp_enable; stop during GAP -> IDLE next cycle.
- REQ-053 Watchdog (FREQ_CHECK_WDOG_EN defined): wd_limit=10, no cmp_done -> wdog_err=1 after 10 WAIT cycles, fail_count+1, no result_valid; without the macro -> block stays in WAIT.
- REQ-054 Reset mid-WAIT, then cmp_done=1 -> all outputs 0, state IDLE, no result_valid.
